// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access sizes, FSM states, defaults.
// Alignment helper is used by both the top and the lane-align sub-module.
package dmem_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE  = 2'b00,
    SIZE_HALF  = 2'b01,
    SIZE_WORD  = 2'b10,
    SIZE_DWORD = 2'b11
  } dmem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } dmem_state_e;

  localparam int DMEM_DEPTH_WORDS_DEFAULT = 64;
  localparam int DMEM_LATENCY_DEFAULT     = 2;

  // Low address bits that must be zero for an access of the given size.
  function automatic logic [2:0] align_mask(input logic [1:0] size);
    case (size)
      SIZE_BYTE: align_mask = 3'b000;
      SIZE_HALF: align_mask = 3'b001;
      SIZE_WORD: align_mask = 3'b011;
      default:   align_mask = 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane logic: merges store data into the addressed word and
// extracts/extends load data from it.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [2:0]  offset,
  input  logic [63:0] wdata,
  input  logic [63:0] rword,
  output logic [63:0] store_word,
  output logic [63:0] load_data
);

  logic [7:0]  byte_en;
  logic [63:0] bit_mask;
  logic [63:0] wdata_shifted;
  logic [63:0] rword_shifted;

  always_comb begin
    byte_en = 8'h00;
    case (size)
      SIZE_BYTE: byte_en = 8'b0000_0001 << offset;
      SIZE_HALF: byte_en = 8'b0000_0011 << offset;
      SIZE_WORD: byte_en = 8'b0000_1111 << offset;
      default:   byte_en = 8'b1111_1111;
    endcase
  end

  always_comb begin
    bit_mask = '0;
    for (int i = 0; i < 8; i++) begin
      bit_mask[i*8 +: 8] = {8{byte_en[i]}};
    end
    wdata_shifted = wdata << {offset, 3'b000};
    store_word    = (rword & ~bit_mask) | (wdata_shifted & bit_mask);
  end

  // Dword loads use the whole word, so the signedness flag has no effect there.
  always_comb begin
    rword_shifted = rword >> {offset, 3'b000};
    case (size)
      SIZE_BYTE: load_data = is_unsigned ? {56'b0, rword_shifted[7:0]}
                                         : {{56{rword_shifted[7]}}, rword_shifted[7:0]};
      SIZE_HALF: load_data = is_unsigned ? {48'b0, rword_shifted[15:0]}
                                         : {{48{rword_shifted[15]}}, rword_shifted[15:0]};
      SIZE_WORD: load_data = is_unsigned ? {32'b0, rword_shifted[31:0]}
                                         : {{32{rword_shifted[31]}}, rword_shifted[31:0]};
      default:   load_data = rword_shifted;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data memory with a valid/ready request and response handshake.
// Define DMEM_MISALIGN_ERR_EN to fault misaligned accesses instead of aligning them down.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS_DEFAULT,
  parameter int LATENCY     = DMEM_LATENCY_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [60:0] DEPTH_LIM = 61'(DEPTH_WORDS);

  dmem_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [63:0]      mem [DEPTH_WORDS];
  logic [IDX_W-1:0] word_idx;
  logic [2:0]       eff_off;
  logic             range_err;
  logic             acc_err;
  logic             mem_wr_en;
  logic [63:0]      store_word;
  logic [63:0]      load_data;

  assign word_idx  = addr_q[3 +: IDX_W];
  assign eff_off   = addr_q[2:0] & ~align_mask(size_q);
  assign range_err = addr_q[63:3] >= DEPTH_LIM;

`ifdef DMEM_MISALIGN_ERR_EN
  assign acc_err = range_err || ((addr_q[2:0] & align_mask(size_q)) != 3'b000);
`else
  assign acc_err = range_err;
`endif

  dmem_lane_align u_lane_align (
    .size        (size_q),
    .is_unsigned (uns_q),
    .offset      (eff_off),
    .wdata       (wdata_q),
    .rword       (range_err ? 64'b0 : mem[word_idx]),
    .store_word  (store_word),
    .load_data   (load_data)
  );

  // The access happens in the WAIT cycle where the counter sits at 0; one more
  // WAIT cycle follows so the response appears LATENCY+1 edges after acceptance.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    we_d      = we_q;
    size_d    = size_q;
    uns_d     = uns_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    mem_wr_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = 4'(LATENCY - 1);
          done_d  = 1'b0;
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (!done_q) begin
          done_d    = 1'b1;
          err_d     = acc_err;
          rdata_d   = (acc_err || we_q) ? 64'b0 : load_data;
          mem_wr_en = we_q && !acc_err;
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      size_q  <= SIZE_BYTE;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is not reset, but a reset edge still suppresses a pending store.
  always_ff @(posedge clk) begin
    if (reset && mem_wr_en) begin
      mem[word_idx] <= store_word;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign busy       = (state_q != ST_IDLE);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (default parameters).
// Misaligned-load expectations follow DMEM_MISALIGN_ERR_EN when it is defined.
module tb_data_mem_responder;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  int nCompared   = 0;
  int nMismatched = 0;

  logic [63:0] rd;
  logic        er;
  int          lat;
  int          seenValid;

  data_mem_responder dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: observed 0x%h expected 0x%h", tag, observed, expected);
    end
  endtask

  // Issues one request, waits (bounded) for the response, optionally holds
  // resp_ready low for holdCycles while checking stability, then accepts it.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [63:0] addr, input logic [63:0] wdata,
                               input int holdCycles,
                               output logic [63:0] rdata, output logic err, output int latency);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = 64'hDEAD_BEEF_DEAD_BEEF;
    req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    latency = 0;
    while (!resp_valid && latency < 50) begin
      @(posedge clk);
      #1;
      latency++;
    end
    if (latency >= 50) checkOutput("resp_timeout", 64'(latency), 64'd3);
    rdata = resp_rdata;
    err   = resp_err;
    for (int i = 0; i < holdCycles; i++) begin
      @(posedge clk);
      #1;
      checkOutput("hold_valid", {63'b0, resp_valid}, 64'd1);
      checkOutput("hold_rdata", resp_rdata, rdata);
      checkOutput("hold_ready", {63'b0, req_ready}, 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    reset        = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    resp_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    checkOutput("rst_req_ready", {63'b0, req_ready}, 64'd1);
    checkOutput("rst_resp_valid", {63'b0, resp_valid}, 64'd0);
    checkOutput("rst_busy", {63'b0, busy}, 64'd0);
    checkOutput("rst_rdata", resp_rdata, 64'd0);
    checkOutput("rst_err", {63'b0, resp_err}, 64'd0);

    applyStimulus(1'b1, 2'b11, 1'b0, 64'h8, 64'h1122_3344_5566_7788, 0, rd, er, lat);
    checkOutput("st_d_err", {63'b0, er}, 64'd0);
    checkOutput("st_d_rdata", rd, 64'd0);
    checkOutput("st_d_lat", 64'(lat), 64'd3);
    checkOutput("idle_after_resp", {63'b0, req_ready}, 64'd1);

    applyStimulus(1'b0, 2'b11, 1'b0, 64'h8, 64'h0, 0, rd, er, lat);
    checkOutput("ld_d_rdata", rd, 64'h1122_3344_5566_7788);
    checkOutput("ld_d_err", {63'b0, er}, 64'd0);
    checkOutput("ld_d_lat", 64'(lat), 64'd3);

    applyStimulus(1'b1, 2'b00, 1'b0, 64'hB, 64'hAAAA_AAAA_AAAA_AAF0, 0, rd, er, lat);
    checkOutput("st_b_err", {63'b0, er}, 64'd0);
    applyStimulus(1'b0, 2'b00, 1'b0, 64'hB, 64'h0, 0, rd, er, lat);
    checkOutput("ld_b_signed", rd, 64'hFFFF_FFFF_FFFF_FFF0);
    applyStimulus(1'b0, 2'b00, 1'b1, 64'hB, 64'h0, 0, rd, er, lat);
    checkOutput("ld_b_unsigned", rd, 64'h0000_0000_0000_00F0);
    applyStimulus(1'b0, 2'b11, 1'b1, 64'h8, 64'h0, 0, rd, er, lat);
    checkOutput("ld_word1_lanes", rd, 64'h1122_3344_F066_7788);
    applyStimulus(1'b0, 2'b01, 1'b0, 64'hA, 64'h0, 0, rd, er, lat);
    checkOutput("ld_h_signed", rd, 64'hFFFF_FFFF_FFFF_F066);
    applyStimulus(1'b0, 2'b01, 1'b0, 64'hC, 64'h0, 0, rd, er, lat);
    checkOutput("ld_h_pos", rd, 64'h0000_0000_0000_3344);
    applyStimulus(1'b0, 2'b10, 1'b0, 64'hC, 64'h0, 0, rd, er, lat);
    checkOutput("ld_w_pos", rd, 64'h0000_0000_1122_3344);

    applyStimulus(1'b1, 2'b11, 1'b0, 64'h10, 64'hAAAA_BBBB_CCCC_DDDD, 0, rd, er, lat);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'b11;
    req_addr  = 64'h10;
    req_wdata = 64'h5555_6666_7777_8888;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checkOutput("wait_busy", {63'b0, busy}, 64'd1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    checkOutput("abort_busy", {63'b0, busy}, 64'd0);
    checkOutput("abort_req_ready", {63'b0, req_ready}, 64'd1);
    seenValid = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (resp_valid) seenValid++;
    end
    checkOutput("abort_no_resp", 64'(seenValid), 64'd0);
    applyStimulus(1'b0, 2'b11, 1'b0, 64'h10, 64'h0, 0, rd, er, lat);
    checkOutput("abort_no_write", rd, 64'hAAAA_BBBB_CCCC_DDDD);

    applyStimulus(1'b0, 2'b11, 1'b0, 64'h8, 64'h0, 5, rd, er, lat);
    checkOutput("hold_rdata_final", rd, 64'h1122_3344_F066_7788);
    checkOutput("hold_idle_next", {63'b0, req_ready}, 64'd1);
    checkOutput("hold_busy_next", {63'b0, busy}, 64'd0);

    applyStimulus(1'b0, 2'b11, 1'b0, 64'h200, 64'h0, 0, rd, er, lat);
    checkOutput("range_err", {63'b0, er}, 64'd1);
    checkOutput("range_rdata", rd, 64'd0);

    applyStimulus(1'b1, 2'b11, 1'b0, 64'h0, 64'h89AB_CDEF_0123_4567, 0, rd, er, lat);
    applyStimulus(1'b0, 2'b10, 1'b0, 64'h6, 64'h0, 0, rd, er, lat);
`ifdef DMEM_MISALIGN_ERR_EN
    checkOutput("misalign_err", {63'b0, er}, 64'd1);
    checkOutput("misalign_rdata", rd, 64'd0);
`else
    checkOutput("misalign_err", {63'b0, er}, 64'd0);
    checkOutput("misalign_rdata", rd, 64'hFFFF_FFFF_89AB_CDEF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 64: number of 64-bit storage words.
REQ-002 Parameter LATENCY, default 2: WAIT-state cycles per access; legal range 1..15.
REQ-003 clk  in  1: single clock; all state changes on rising edge.
REQ-004 reset  in  1: synchronous, active-low; reset=0 at a rising edge resets the block.
REQ-005 req_valid  in  1: request offered by the MEM stage.
REQ-006 req_ready  out  1: responder can accept a request.
REQ-007 req_we  in  1: 1=store, 0=load.
REQ-008 req_size  in  2: 00 byte, 01 half, 10 word, 11 dword.
REQ-009 req_unsigned  in  1: load zero-extends when 1; sign-extends when 0.
REQ-010 req_addr  in  64: byte address.
REQ-011 req_wdata  in  64: store data, right-justified.
REQ-012 resp_valid  out  1: response available.
REQ-013 resp_ready  in  1: MEM stage accepts the response.
REQ-014 resp_rdata  out  64: extended load data; 0 for stores and errors.
REQ-015 resp_err  out  1: access faulted.
REQ-016 busy  out  1: high in any state other than IDLE.

Function
REQ-017 FSM states: IDLE, WAIT, RESP.
REQ-018 req_ready shall be 1 only in IDLE.
REQ-019 A handshake (req_valid and req_ready both 1) shall latch we/size/unsigned/addr/wdata, load the wait counter with LATENCY-1, and enter WAIT.
REQ-020 In WAIT the counter shall decrement each cycle; at count 0 the access is performed and the FSM enters RESP.
REQ-021 Access latency: resp_valid rises exactly LATENCY+1 cycles after the accepting edge.
REQ-022 In RESP, resp_valid shall hold at 1 with stable data/err until resp_ready=1. That edge returns the FSM to IDLE.
REQ-023 No request is accepted in the cycle a response completes; the next acceptance is possible at the following edge.
REQ-024 Word index = addr[63:3]. An index >= DEPTH_WORDS shall set resp_err=1, perform no write, and return rdata 0.
REQ-025 A store shall write only the byte lanes selected by size and addr[2:0]; other lanes are unchanged.
REQ-026 A load shall select the lanes given by size and addr[2:0], shift them to bit 0, then extend per req_unsigned; dword ignores req_unsigned.
REQ-027 Inputs other than req_valid are ignored outside the acceptance cycle.

Reset
REQ-028 Reset shall force: state IDLE, counter 0, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, busy 0.
REQ-029 Reset in WAIT or RESP shall abandon the access. A store not yet performed shall not write, and no response shall be issued.
REQ-030 Storage array contents are not reset.

Configuration
REQ-031 With DMEM_MISALIGN_ERR_EN defined, a misaligned access (addr not a multiple of the size) shall complete with resp_err=1, perform no write, and return rdata 0.
REQ-032 Without DMEM_MISALIGN_ERR_EN, misaligned accesses shall force the low address bits to the size alignment, and resp_err shall reflect range errors only.

Structure
REQ-033 Shared package dmem_pkg shall hold: the size encodings, the FSM state enum, and the LATENCY/DEPTH default constants.
REQ-034 A sub-module dmem_lane_align shall hold the combinational lane select/extend (load) and byte-enable/shift (store) logic.

Verification
REQ-035 Reset then release: req_ready=1, resp_valid=0, busy=0. Assert reset during WAIT of a store to 0x10: the word at 0x10 is unchanged and resp_valid never rises.
REQ-036 Store dword 0x1122334455667788 @0x8, then load dword @0x8 with LATENCY=2: response at cycle 3 after accept, rdata=0x1122334455667788, err=0.
REQ-037 Store byte 0xF0 @0xB, then signed byte load @0xB returns 0xFFFFFFFFFFFFFFF0, and unsigned returns 0x00000000000000F0; the other bytes of word 1 are unchanged.
REQ-038 Hold resp_ready=0 for 5 cycles after resp_valid: resp_valid and rdata remain stable and req_ready=0. Pulse resp_ready: IDLE next cycle.
REQ-039 Load @0x200 (index 64, DEPTH_WORDS=64): err=1, rdata=0. Word load @0x6 returns err=1 with DMEM_MISALIGN_ERR_EN defined, and returns the word @0x4 without it.
